// File: rtl/fwd_hazard_unit_if.sv
// ID-side bundle of the forwarding/hazard unit: decoded ID fields and
// pipeline controls in, stall/bubble/forward selects and stall counter out.
interface fwd_hazard_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             freeze;
    logic             flush;
    logic             id_valid;
    logic [AW-1:0]    id_rs1;
    logic [AW-1:0]    id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [AW-1:0]    id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             stall;
    logic             bubble;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output freeze, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread,
        input  stall, bubble, forward_a, forward_b, stall_count
    );

    modport slave (
        input  freeze, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread,
        output stall, bubble, forward_a, forward_b, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destination registers through EX (_p1) and MEM (_p2),
// registers EX operand-forward selects and raises one-cycle load-use stalls.
module fwd_hazard_unit #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_unit_if.slave hz
);

    logic          r_vld_p1;
    logic [AW-1:0] r_rd_p1;
    logic          r_rw_p1;
    logic          r_ld_p1;
    logic          r_vld_p2;
    logic [AW-1:0] r_rd_p2;
    logic          r_rw_p2;

    logic             r_bubble;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_hit_rs1;
    logic       w_hit_rs2;
    logic       w_stall;
    logic       w_enter_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Selection as seen one cycle later: the EX occupant will be in MEM, the MEM one in WB.
    function automatic logic [1:0] fwd_sel(
        input logic          use_rs,
        input logic [AW-1:0] rs,
        input logic          ex_vld,
        input logic          ex_rw,
        input logic          ex_ld,
        input logic [AW-1:0] ex_rd,
        input logic          mem_vld,
        input logic          mem_rw,
        input logic [AW-1:0] mem_rd
    );
        logic live;
        live = use_rs && (rs != '0);
        if (live && ex_vld && ex_rw && !ex_ld && (rs == ex_rd)) return 2'b10;
        if (live && mem_vld && mem_rw && (rs == mem_rd)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    always_comb begin
        w_hit_rs1 = hz.id_use_rs1 && (hz.id_rs1 == r_rd_p1);
        w_hit_rs2 = hz.id_use_rs2 && (hz.id_rs2 == r_rd_p1);
        w_stall   = !rst && hz.id_valid && r_vld_p1 && r_ld_p1 && r_rw_p1 &&
                    (r_rd_p1 != '0) && (w_hit_rs1 || w_hit_rs2) &&
                    !hz.flush && !hz.freeze;
        w_enter_bubble = w_stall || hz.flush || !hz.id_valid;
        w_fwd_a = fwd_sel(hz.id_use_rs1, hz.id_rs1, r_vld_p1, r_rw_p1, r_ld_p1,
                          r_rd_p1, r_vld_p2, r_rw_p2, r_rd_p2);
        w_fwd_b = fwd_sel(hz.id_use_rs2, hz.id_rs2, r_vld_p1, r_rw_p1, r_ld_p1,
                          r_rd_p1, r_vld_p2, r_rw_p2, r_rd_p2);
    end

    // ID -> EX (_p1) -> MEM (_p2)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_rw_p1     <= 1'b0;
            r_ld_p1     <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_rw_p2     <= 1'b0;
            r_bubble    <= 1'b1;
            r_fwd_a     <= 2'b00;
            r_fwd_b     <= 2'b00;
            r_stall_cnt <= '0;
        end else if (!hz.freeze) begin
            r_vld_p2 <= r_vld_p1;
            r_rw_p2  <= r_rw_p1;
            r_rd_p2  <= r_rd_p1;
            r_bubble <= w_enter_bubble;
            if (w_enter_bubble) begin
                r_vld_p1 <= 1'b0;
                r_rw_p1  <= 1'b0;
                r_ld_p1  <= 1'b0;
                r_fwd_a  <= 2'b00;
                r_fwd_b  <= 2'b00;
            end else begin
                r_vld_p1 <= 1'b1;
                r_rw_p1  <= hz.id_regwrite;
                r_ld_p1  <= hz.id_memread;
                r_rd_p1  <= hz.id_rd;
                r_fwd_a  <= w_fwd_a;
                r_fwd_b  <= w_fwd_b;
            end
            if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign hz.stall       = w_stall;
    assign hz.bubble      = r_bubble;
    assign hz.forward_a   = r_fwd_a;
    assign hz.forward_b   = r_fwd_b;
    assign hz.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit (CNT_W = 2 so saturation is reachable).
module tb_fwd_hazard_unit;

    localparam int AW    = 5;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } instr_t;

    typedef struct {
        string            tag;
        logic             bub;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t sbq[$];

    fwd_hazard_unit_if #(.AW(AW), .CNT_W(CNT_W)) ifc ();

    fwd_hazard_unit #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        instr_t i;
        i.v = 1'b1; i.rs1 = AW'(rs1); i.rs2 = AW'(rs2); i.u1 = 1'b1; i.u2 = 1'b1;
        i.rd = AW'(rd); i.rw = 1'b1; i.mr = 1'b0;
        return i;
    endfunction

    function automatic instr_t ld(input int rd, input int rs1);
        instr_t i;
        i.v = 1'b1; i.rs1 = AW'(rs1); i.rs2 = '0; i.u1 = 1'b1; i.u2 = 1'b0;
        i.rd = AW'(rd); i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    task automatic drive(input instr_t in, input logic fl, input logic fz, input logic rs);
        rst             = rs;
        ifc.flush       = fl;
        ifc.freeze      = fz;
        ifc.id_valid    = in.v;
        ifc.id_rs1      = in.rs1;
        ifc.id_rs2      = in.rs2;
        ifc.id_use_rs1  = in.u1;
        ifc.id_use_rs2  = in.u2;
        ifc.id_rd       = in.rd;
        ifc.id_regwrite = in.rw;
        ifc.id_memread  = in.mr;
    endtask

    // Drive one ID cycle, check stall combinationally, then score EX-side outputs after the edge.
    task automatic issue(input string tag, input instr_t in, input logic fl, input logic fz,
                         input logic rs, input logic es, input logic eb,
                         input logic [1:0] efa, input logic [1:0] efb,
                         input logic [CNT_W-1:0] ec);
        exp_t e;
        drive(in, fl, fz, rs);
        #1;
        check_eq({tag, ".stall"}, 32'(ifc.stall), 32'(es));
        e.tag = tag; e.bub = eb; e.fa = efa; e.fb = efb; e.cnt = ec;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_eq({e.tag, ".bubble"}, 32'(ifc.bubble), 32'(e.bub));
        check_eq({e.tag, ".fwd_a"}, 32'(ifc.forward_a), 32'(e.fa));
        check_eq({e.tag, ".fwd_b"}, 32'(ifc.forward_b), 32'(e.fb));
        check_eq({e.tag, ".cnt"}, 32'(ifc.stall_count), 32'(e.cnt));
    endtask

    initial begin
        instr_t c;
        logic [CNT_W-1:0] prev;
        logic [CNT_W-1:0] nxt;
        n_vec = 0;
        n_err = 0;
        drive(nop(), 1'b0, 1'b0, 1'b1);

        issue("rst_a", nop(), 0, 0, 1, 0, 1, 2'b00, 2'b00, 0);
        issue("rst_b", alu(5, 5, 5), 0, 0, 1, 0, 1, 2'b00, 2'b00, 0);

        // EX/MEM forwarding, then WB forwarding across one independent instruction
        issue("add5",  alu(5, 1, 2),  0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("sub6",  alu(6, 5, 3),  0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        issue("prod7", alu(7, 1, 2),  0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("ind9",  alu(9, 1, 3),  0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("cons7", alu(10, 4, 7), 0, 0, 0, 0, 0, 2'b00, 2'b01, 0);

        // Load-use: one stall cycle, bubble, then WB forward on re-presentation
        issue("lw8",    ld(8, 1),       0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        issue("use8",   alu(11, 8, 2),  0, 0, 0, 1, 1, 2'b00, 2'b00, 1);
        issue("use8r",  alu(11, 8, 2),  0, 0, 0, 0, 0, 2'b01, 2'b00, 1);

        // x0 is never forwarded and never stalls
        issue("wr_x0",  alu(0, 1, 2),   0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        issue("rd_x0",  alu(12, 0, 0),  0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        issue("lw_x0",  ld(0, 1),       0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        issue("use_x0", alu(14, 0, 2),  0, 0, 0, 0, 0, 2'b00, 2'b00, 1);

        // Flush beats the hazard
        issue("lw13",   ld(13, 1),      0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        issue("use13f", alu(14, 13, 2), 1, 0, 0, 0, 1, 2'b00, 2'b00, 1);

        // Freeze holds everything, then the hazard stalls once
        issue("lw15",   ld(15, 13),     0, 0, 0, 0, 0, 2'b01, 2'b00, 1);
        c = alu(16, 1, 15);
        for (int i = 0; i < 3; i++)
            issue($sformatf("frz%0d", i), c, 0, 1, 0, 0, 0, 2'b01, 2'b00, 1);
        issue("use15",  c, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2);
        issue("use15r", c, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2);

        // Counter saturation after a fresh reset
        issue("rst_c", nop(), 0, 0, 1, 0, 1, 2'b00, 2'b00, 0);
        for (int k = 0; k < 5; k++) begin
            prev = (k > 3) ? CNT_W'(3) : CNT_W'(k);
            nxt  = (k + 1 > 3) ? CNT_W'(3) : CNT_W'(k + 1);
            c = alu(25, 16 + k, 3);
            issue($sformatf("sat_lw%0d", k), ld(16 + k, 0), 0, 0, 0, 0, 0, 2'b00, 2'b00, prev);
            issue($sformatf("sat_use%0d", k), c, 0, 0, 0, 1, 1, 2'b00, 2'b00, nxt);
            issue($sformatf("sat_rep%0d", k), c, 0, 0, 0, 0, 0, 2'b01, 2'b00, nxt);
        end

        // Reset asserted while a load-use stall is pending
        issue("lw21", ld(21, 0), 0, 0, 0, 0, 0, 2'b00, 2'b00, 3);
        c = alu(26, 21, 3);
        drive(c, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("pre_rst.stall", 32'(ifc.stall), 32'd1);
        issue("rst_mid",  c, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0);
        issue("post_rst", c, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Tracks destination registers of in-flight instructions through EX, MEM and WB.
- Produces registered 2-bit operand-select codes for the EX-stage operand forwarding muxes: 00 register file, 01 WB data, 10 EX/MEM ALU result.
- Detects load-use hazards and drives a one-cycle stall with bubble insertion.
- Sits between ID decode and the ID/EX pipeline register; also provides a saturating stall counter.

Parameters:
- AW, 5, register address width.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  global pipeline hold (memory wait); all internal state holds.
- flush  input  1  branch/jump taken in EX; squash ID instruction.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  AW  source register 1 of ID instruction.
- id_rs2  input  AW  source register 2 of ID instruction.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  AW  destination register of ID instruction.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- stall  output  1  combinational; hold PC and IF/ID, insert bubble into ID/EX.
- bubble  output  1  registered; the instruction now in EX is a bubble.
- forward_a  output  2  registered select for EX operand A mux.
- forward_b  output  2  registered select for EX operand B mux.
- stall_count  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: all tracking valid bits 0, forward_a = forward_b = 00, bubble = 1, stall_count = 0. stall = 0 while rst = 1.
- Internal stages:
  - EX: ex_valid, ex_rd, ex_regwrite, ex_memread.
  - MEM: mem_valid, mem_rd, mem_regwrite.
  - Each clock without freeze: MEM <- EX, EX <- ID entry or bubble.
  - An empty stage has valid = 0 and regwrite = 0.
- Load-use hazard (combinational): stall = id_valid & ex_valid & ex_memread & ex_regwrite & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & ~flush & ~freeze.
- EX entry: a bubble (valid 0) is entered on stall, flush, or ~id_valid; otherwise the ID fields are entered. bubble <- 1 on bubble entry, else 0.
- Forward select, computed at ID and registered into EX (latency 1, valid in the cycle the instruction is in EX):
  - 10 if use & rs != 0 & ex_valid & ex_regwrite & ~ex_memread & rs == ex_rd. The producer will be in MEM, so the ALU result is used.
  - else 01 if use & rs != 0 & mem_valid & mem_regwrite & rs == mem_rd. The producer will be in WB.
  - else 00.
  - A load in EX never yields 10. After a load-use stall, the load is in MEM at the re-evaluation, so the consumer gets 01.
- Bubble entry forces forward_a = forward_b = 00.
- x0 is never forwarded.
- A producer three ahead (in WB during the consumer's ID cycle) is not handled here; the register file is write-first.
- Priority:
  - rst > freeze > flush > stall > normal.
  - freeze: every register holds, including forward_a/b, bubble and stall_count; stall = 0.
  - flush with hazard: bubble entered, stall = 0, counter unchanged.
- stall_count increments by 1 on each clock where stall = 1 and saturates at 2^CNT_W - 1 (no wrap).
- Reset mid-stall: next cycle all state is at reset values and stall = 0.

Test Plan:
- Reset, then `add x5,x1,x2` followed by `sub x6,x5,x3` (id_rs1 = 5) -> the cycle sub is in EX: forward_a = 10, forward_b = 00, stall never 1.
- Producer rd = 7, one independent instruction, then consumer with rs2 = 7 -> consumer in EX: forward_b = 01, forward_a = 00.
- `lw x8` then consumer with rs1 = 8:
  - stall = 1 for exactly one cycle; bubble = 1 the next cycle.
  - Re-presented consumer reaches EX with forward_a = 01.
  - stall_count = 1.
- Producer writes x0, consumer reads x0 -> forward_a = 00; load to x0 followed by a consumer of x0 -> no stall.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0, bubble entered, stall_count unchanged. Same hazard with freeze = 1 for 3 cycles -> stall = 0, outputs held; after freeze drops, stall = 1 once.
- CNT_W = 2, five consecutive load-use pairs -> stall_count reads 1, 2, 3, 3, 3. Assert rst while stall = 1 -> next cycle stall = 0, forward_a/b = 00, stall_count = 0.
